// File: rtl/alu_div_sequencer.sv
// Multi-cycle RV32M divide sequencer (DIV/DIVU/REM/REMU) that borrows the
// shared execute-stage ALU for every subtraction/negation it needs.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, op           request pulse (sampled in IDLE only), 00 DIV 01 DIVU 10 REM 11 REMU
//   dividend, divisor   rs1 / rs2, captured on the accepted start
//   busy, done, result  status, one-cycle done pulse, held quotient/remainder
//   alu_a/b/select      shared ALU drive, valid while busy (idle: 0/0/ADD)
//   alu_out             combinational ALU result, consumed in the same cycle
module alu_div_sequencer #(
  parameter int unsigned XLEN    = 32,
  parameter logic [3:0]  SEL_SUB = 4'b1000,
  parameter logic [3:0]  SEL_ADD = 4'b0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_select,
  input  logic [XLEN-1:0] alu_out
);

  localparam int unsigned     CNT_W   = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_NEG_A, S_NEG_B, S_ITER, S_FIX, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, r_q, r_d, q_q, q_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic              busy_d, done_d;
  logic [XLEN-1:0]   result_d;

  // Restoring-division step helpers, all derived from registered state.
  logic [XLEN-1:0] r_shift;
  logic            borrow, ge;
  logic [XLEN-1:0] fix_x;
  logic            fix_neg;

  assign r_shift = {r_q[XLEN-2:0], q_q[XLEN-1]};
  // Unsigned r_shift < b_q, recovered from the ALU difference sign bit.
  assign borrow  = (~r_shift[XLEN-1] & b_q[XLEN-1]) |
                   (~(r_shift[XLEN-1] ^ b_q[XLEN-1]) & alu_out[XLEN-1]);
  // A set bit shifted out of R means the 33-bit partial remainder exceeds B.
  assign ge      = r_q[XLEN-1] | ~borrow;
  assign fix_x   = op_q[1] ? r_q : q_q;
  assign fix_neg = op_q[1] ? sa_q : (sa_q ^ sb_q);

  // Next-state, datapath and ALU drive.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    r_d        = r_q;
    q_d        = q_q;
    cnt_d      = cnt_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    result_d   = result;
    alu_a      = '0;
    alu_b      = '0;
    alu_select = SEL_ADD;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d = op;
          a_d  = dividend;
          b_d  = divisor;
          sa_d = dividend[XLEN-1] & ~op[0];
          sb_d = divisor[XLEN-1] & ~op[0];
          if (divisor == '0) begin
            result_d = op[1] ? dividend : '1;
            state_d  = S_DONE;
          end else if (~op[0] && dividend == MIN_NEG && divisor == '1) begin
            result_d = op[1] ? '0 : MIN_NEG;
            state_d  = S_DONE;
          end else begin
            state_d = S_NEG_A;
          end
        end
      end
      S_NEG_A: begin
        alu_b      = a_q;
        alu_select = SEL_SUB;
        if (sa_q) a_d = alu_out;
        state_d = S_NEG_B;
      end
      S_NEG_B: begin
        alu_b      = b_q;
        alu_select = SEL_SUB;
        if (sb_q) b_d = alu_out;
        // A is already magnitude here; seed the quotient shifter with it.
        q_d     = a_q;
        r_d     = '0;
        cnt_d   = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        alu_a      = r_shift;
        alu_b      = b_q;
        alu_select = SEL_SUB;
        r_d        = ge ? alu_out : r_shift;
        q_d        = {q_q[XLEN-2:0], ge};
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        alu_b      = fix_x;
        alu_select = SEL_SUB;
        result_d   = fix_neg ? alu_out : fix_x;
        state_d    = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      busy    <= busy_d;
      done    <= done_d;
      result  <= result_d;
    end
  end

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Bench for alu_div_sequencer: behavioural shared ALU, directed vector table
// plus hand sequences for overlap, start-in-DONE and mid-operation reset.
module tb_alu_div_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend, divisor;
  logic        busy, done;
  logic [31:0] result, alu_a, alu_b, alu_out;
  logic [3:0]  alu_select;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Shared ALU: subtract on SEL_SUB, add otherwise.
  assign alu_out = (alu_select == 4'b1000) ? (alu_a - alu_b) : (alu_a + alu_b);

  alu_div_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .result(result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_out(alu_out)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one operation in the current (IDLE) cycle and wait for done.
  // poke: cycle at which a stray start is raised while busy (0 = none).
  // poke_done: raise start in the DONE cycle and check it is ignored.
  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input int poke, input bit poke_done,
                     output int lat, output logic [31:0] res,
                     output logic busy1, output logic [3:0] sel1);
    @(negedge clk);
    start = 1'b1; op = o; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    op = 2'($urandom); dividend = $urandom; divisor = $urandom;
    busy1 = busy; sel1 = alu_select;
    lat = -1; res = 'x;
    for (int c = 1; c <= 60; c++) begin
      if (done) begin
        lat = c; res = result;
        if (poke_done) begin
          start = 1'b1; op = 2'b01; dividend = 32'd9; divisor = 32'd2;
        end
        break;
      end
      if (c == poke) begin
        start = 1'b1; op = 2'b00; dividend = 32'd1000; divisor = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    if (poke_done) chk("start_in_done_ignored", 32'(busy), 32'd0);
    start = 1'b0;
    chk("done_single_pulse", 32'(done), 32'd0);
  endtask

  int          lat;
  logic [31:0] res;
  logic        busy1, seen_done;
  logic [3:0]  sel1;

  initial begin
    vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         36};
    vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          36};
    vecs[2]  = '{2'b00, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   36};
    vecs[3]  = '{2'b10, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   36};
    vecs[4]  = '{2'b10, 32'd7,          32'hFFFFFFFE,   32'd1,          36};
    vecs[5]  = '{2'b00, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   36};
    vecs[6]  = '{2'b01, 32'hFFFFFFFF,   32'h80000001,   32'd1,          36};
    vecs[7]  = '{2'b11, 32'hFFFFFFFF,   32'h80000001,   32'h7FFFFFFE,   36};
    vecs[8]  = '{2'b00, 32'd5,          32'd0,          32'hFFFFFFFF,   1};
    vecs[9]  = '{2'b10, 32'd5,          32'd0,          32'd5,          1};
    vecs[10] = '{2'b11, 32'd5,          32'd0,          32'd5,          1};
    vecs[11] = '{2'b00, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1};
    vecs[12] = '{2'b10, 32'h80000000,   32'hFFFFFFFF,   32'd0,          1};
    vecs[13] = '{2'b01, 32'h80000000,   32'hFFFFFFFF,   32'd0,          36};

    rst = 1'b1; start = 1'b0; op = '0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_done",   32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_alu_a",  alu_a, 32'd0);
    chk("rst_alu_b",  alu_b, 32'd0);
    chk("rst_alu_sel", 32'(alu_select), 32'd0);

    // Back-to-back operations, each started in the first IDLE cycle.
    for (int i = 0; i < 14; i++) begin
      run(vecs[i].op, vecs[i].a, vecs[i].b, 0, 1'b0, lat, res, busy1, sel1);
      chk($sformatf("v%0d_result", i), res, vecs[i].exp);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_busy_c1", i), 32'(busy1), 32'd1);
      if (vecs[i].lat != 1) chk($sformatf("v%0d_sel_c1", i), 32'(sel1), 32'h8);
    end

    // Stray start while busy must not disturb the running operation.
    run(2'b01, 32'd100, 32'd7, 5, 1'b0, lat, res, busy1, sel1);
    chk("overlap_result", res, 32'd14);
    chk("overlap_latency", 32'(lat), 32'd36);

    // Start raised in the DONE cycle is dropped.
    run(2'b11, 32'd100, 32'd7, 0, 1'b1, lat, res, busy1, sel1);
    chk("donestart_result", res, 32'd2);

    // Reset at cycle 20 of an operation aborts it silently.
    @(negedge clk);
    start = 1'b1; op = 2'b01; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy",   32'(busy), 32'd0);
    chk("midrst_done",   32'(done), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_alu_sel", 32'(alu_select), 32'd0);
    seen_done = 1'b0;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk); #1;
      seen_done |= done;
    end
    chk("midrst_no_done", 32'(seen_done), 32'd0);

    run(2'b00, 32'hFFFFFFF9, 32'd2, 0, 1'b0, lat, res, busy1, sel1);
    chk("postrst_result", res, 32'hFFFFFFFD);
    chk("postrst_latency", 32'(lat), 32'd36);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
